dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter/sequencer in front of the single-ported data memory; shares it between requester 0 (core load/store unit) and requester 1 (debug/DMA port).
- Round-robin grant, valid/ready request and response handshakes per port.
- Runs exactly one memory access at a time; rejects illegal accesses (misaligned, out of range, bad funct3) without touching memory.

Parameters:
- MEM_DEPTH, 1024, data memory depth in 32-bit words; legal byte addresses are 0 to 4*MEM_DEPTH-1.
- ADDR_W, 32, request address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; one-hot or zero.
- req_write  in  2  per-requester: 1 = store, 0 = load.
- req_addr  in  2xADDR_W  per-requester byte address.
- req_wdata  in  2x32  per-requester store data, right-aligned.
- req_funct3  in  2x3  per-requester RISC-V load/store funct3.
- resp_valid  out  2  per-requester response valid.
- resp_ready  in  2  per-requester response accept.
- resp_rdata  out  32  load result, shared by both ports; meaningful only with resp_valid.
- resp_err  out  1  access rejected, shared; meaningful only with resp_valid.
- mem_read  out  1  to memory read enable.
- mem_write  out  1  to memory write enable.
- mem_address  out  32  to memory byte address.
- mem_write_data  out  32  to memory store data.
- mem_funct3  out  3  to memory access size/sign.
- mem_read_data  in  32  from memory; combinational read of the presented address.

Behaviour:
- Reset values:
  - state = IDLE.
  - req_ready, resp_valid, mem_read, mem_write, resp_err = 0.
  - resp_rdata, mem_address, mem_write_data, mem_funct3 = 0.
  - last_grant = 1, so requester 0 wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - winner = the only valid requester; if both are valid, the one not equal to last_grant.
  - req_ready[winner] = 1, combinational, IDLE only.
  - On handshake, register write, addr, wdata, funct3, the owner id and the legality check; set last_grant = winner.
  - Next state: legal -> ACCESS; illegal -> RESP with resp_err = 1 and resp_rdata = 0.
  - No requests -> stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_read = !write; mem_write = write; mem_* driven from the registered fields.
  - At end of cycle: loads capture mem_read_data into resp_rdata; stores set resp_rdata = 0. resp_err = 0.
  - Next state is RESP.
- RESP:
  - resp_valid[owner] = 1; resp_rdata and resp_err held stable.
  - Leave to IDLE on resp_ready[owner]; otherwise stall indefinitely.
  - No new request is accepted while in RESP or ACCESS.
- mem_read and mem_write are decoded from state and are 0 outside ACCESS; mem_address, mem_write_data and mem_funct3 hold their last registered values.
- Legality check, at accept time:
  - Address: addr < 4*MEM_DEPTH.
  - Store funct3 must be in {000, 001, 010}; load funct3 must be in {000, 001, 010, 100, 101}.
  - Alignment: halfword (001/101) needs addr[0] = 0; word (010) needs addr[1:0] = 0.
  - Any failure means illegal.
- Latency:
  - Accept at edge T, ACCESS in cycle T+1, resp_valid from cycle T+2.
  - Peak throughput is 1 transaction per 3 cycles with resp_ready held high.
- Simultaneous events:
  - A requester may hold req_valid while its own response is pending; it is not re-granted until IDLE.
  - A requester deasserting req_valid before it is granted is legal and loses no state.
- Reset mid-operation:
  - Asserting rst in ACCESS drops mem_write and mem_read immediately (asynchronous), so no store commits on the next edge.
  - The pending transaction is discarded and no response is issued.

Test Plan:
- Req0 stores SW addr 0x10 data 0xDEADBEEF, then loads LW 0x10 -> one mem_write pulse in ACCESS; load response resp_rdata = 0xDEADBEEF, resp_err = 0, resp_valid at accept+2.
- Both ports request every cycle for 6 transactions, resp_ready = 1 -> grants alternate 0,1,0,1,0,1 starting with 0; never two ready bits set.
- Req1 issues LH at 0x13, then SW at 0x1002 -> resp_err = 1, resp_rdata = 0, mem_read/mem_write never asserted; a store funct3 = 100 also gives resp_err = 1.
- Req0 LB at 0x11 after SW 0x10 = 0x00008000, holding resp_ready = 0 for 5 cycles -> resp_valid and resp_rdata = 0xFFFFFF80 stable throughout; req1 is not granted until one cycle after the handshake.
- Assert rst during the ACCESS cycle of an SW to 0x20 -> mem_write drops at once; after reset, LW 0x20 returns the old value; outputs equal reset values.
- Req0 LHU at addr 4*MEM_DEPTH-2 with that halfword = 0xBEEF -> resp_rdata = 0x0000BEEF, no error (upper-bound legality).

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin two-port sequencer in front of a single-ported data memory.
// One access in flight; illegal requests are answered with an error and never reach memory.
module dmem_arbiter #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_write,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][31:0]       req_wdata,
    input  logic [1:0][2:0]        req_funct3,
    output logic [1:0]             resp_valid,
    input  logic [1:0]             resp_ready,
    output logic [31:0]            resp_rdata,
    output logic                   resp_err,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [31:0]            mem_address,
    output logic [31:0]            mem_write_data,
    output logic [2:0]             mem_funct3,
    input  logic [31:0]            mem_read_data
);

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MEM_BYTES = 4 * MEM_DEPTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic                r_last_grant;
    logic                r_owner;
    logic                r_write;
    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [2:0]          r_funct3;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic                w_winner;
    logic                w_accept;
    logic                w_wr;
    logic [ADDR_W-1:0]   w_addr;
    logic [2:0]          w_f3;
    logic                w_in_range;
    logic                w_f3_ok;
    logic                w_aligned;
    logic                w_legal;

    // On a tie the requester that did not win last time gets the grant.
    assign w_winner = (&req_valid) ? ~r_last_grant : req_valid[1];
    assign w_wr     = req_write[w_winner];
    assign w_addr   = req_addr[w_winner];
    assign w_f3     = req_funct3[w_winner];

    always_comb begin
        w_in_range = (64'(w_addr) < 64'(MEM_BYTES));
        w_f3_ok    = 1'b0;
        w_aligned  = 1'b0;
        case (w_f3)
            3'b000: begin w_f3_ok = 1'b1;  w_aligned = 1'b1;                 end
            3'b001: begin w_f3_ok = 1'b1;  w_aligned = ~w_addr[0];           end
            3'b010: begin w_f3_ok = 1'b1;  w_aligned = (w_addr[1:0] == 2'b00); end
            3'b100: begin w_f3_ok = ~w_wr; w_aligned = 1'b1;                 end
            3'b101: begin w_f3_ok = ~w_wr; w_aligned = ~w_addr[0];           end
            default: begin w_f3_ok = 1'b0; w_aligned = 1'b0;                 end
        endcase
        w_legal = w_in_range & w_f3_ok & w_aligned;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Handshake strobes and memory enables decode straight from state.
    always_comb begin
        w_next_state = r_state;
        req_ready    = 2'b00;
        resp_valid   = 2'b00;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req_valid) begin
                    req_ready    = w_winner ? 2'b10 : 2'b01;
                    w_accept     = 1'b1;
                    w_next_state = w_legal ? S_ACCESS : S_RESP;
                end
            end
            S_ACCESS: begin
                mem_read     = ~r_write;
                mem_write    = r_write;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                resp_valid = r_owner ? 2'b10 : 2'b01;
                if (resp_ready[r_owner]) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_funct3     <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_winner;
                r_owner      <= w_winner;
                r_write      <= w_wr;
                r_addr       <= 32'(w_addr);
                r_wdata      <= req_wdata[w_winner];
                r_funct3     <= w_f3;
                if (!w_legal) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
            end
            if (r_state == S_ACCESS) begin
                r_rdata <= r_write ? '0 : mem_read_data;
                r_err   <= 1'b0;
            end
        end
    end

    assign mem_address    = r_addr;
    assign mem_write_data = r_wdata;
    assign mem_funct3     = r_funct3;
    assign resp_rdata     = r_rdata;
    assign resp_err       = r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a data memory, a transaction-level reference model checked every
// cycle, and directed scenarios with literal expectations.
module tb_dmem_arbiter;

    localparam int unsigned MEM_DEPTH = 1024;
    localparam int unsigned MEM_BYTES = 4 * MEM_DEPTH;
    localparam int unsigned IW        = $clog2(MEM_DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_write;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0][2:0]  req_funct3;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [31:0]      resp_rdata;
    logic             resp_err;
    logic             mem_read;
    logic             mem_write;
    logic [31:0]      mem_address;
    logic [31:0]      mem_write_data;
    logic [2:0]       mem_funct3;
    logic [31:0]      mem_read_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_funct3(mem_funct3),
        .mem_read_data(mem_read_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-organised data memory with sized, sign-aware combinational reads.
    logic [31:0] dmem [0:MEM_DEPTH-1];

    always_comb begin : env_rd
        logic [31:0] wv;
        logic [31:0] v;
        wv = dmem[mem_address[IW+1:2]];
        v  = wv >> (8 * mem_address[1:0]);
        case (mem_funct3)
            3'b000:  mem_read_data = {{24{v[7]}}, v[7:0]};
            3'b001:  mem_read_data = {{16{v[15]}}, v[15:0]};
            3'b010:  mem_read_data = wv;
            3'b100:  mem_read_data = {24'h0, v[7:0]};
            3'b101:  mem_read_data = {16'h0, v[15:0]};
            default: mem_read_data = 32'h0;
        endcase
    end

    always @(posedge clk) begin : env_wr
        logic [31:0] m;
        if (mem_write) begin
            m = (mem_funct3 == 3'b000) ? 32'hFF : (mem_funct3 == 3'b001) ? 32'hFFFF : 32'hFFFF_FFFF;
            m = m << (8 * mem_address[1:0]);
            dmem[mem_address[IW+1:2]] <= (dmem[mem_address[IW+1:2]] & ~m)
                                       | ((mem_write_data << (8 * mem_address[1:0])) & m);
        end
    end

    // Reference model: byte memory plus one outstanding transaction.
    logic [7:0]  ref_mem [0:MEM_BYTES-1];
    bit          m_pend = 1'b0;
    bit          m_last = 1'b1;
    int          m_age;
    bit          m_legal, m_owner, m_wr, m_w, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [2:0]  m_f3;
    logic [1:0]  e_ready, e_rv;
    bit          e_rd, e_wr;
    int          grant_log[$];
    int          wr_pulses = 0;
    int          mem_act   = 0;

    function automatic bit legal(input bit wr, input logic [31:0] a, input logic [2:0] f);
        int sz;
        bit ok;
        if (a >= MEM_BYTES) return 1'b0;
        if (wr) ok = f inside {3'b000, 3'b001, 3'b010};
        else    ok = f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        if (!ok) return 1'b0;
        sz = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
        return (int'(a) % sz) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f);
        int i;
        logic [15:0] h;
        i = int'(a);
        case (f)
            3'b000:  return {{24{ref_mem[i][7]}}, ref_mem[i]};
            3'b100:  return {24'h0, ref_mem[i]};
            3'b001:  begin h = {ref_mem[i+1], ref_mem[i]}; return {{16{h[15]}}, h}; end
            3'b101:  begin h = {ref_mem[i+1], ref_mem[i]}; return {16'h0, h}; end
            default: return {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
        endcase
    endfunction

    function automatic void ref_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
        int n;
        n = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
        for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = d[8*k +: 8];
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            m_pend = 1'b0;
            m_last = 1'b1;
        end else begin
            e_ready = 2'b00;
            e_rv    = 2'b00;
            e_rd    = 1'b0;
            e_wr    = 1'b0;
            m_w     = 1'b0;
            if (!m_pend && req_valid != 2'b00) begin
                m_w     = (req_valid == 2'b11) ? !m_last : req_valid[1];
                e_ready = m_w ? 2'b10 : 2'b01;
            end
            if (m_pend && m_legal && m_age == 1) begin
                e_rd = !m_wr;
                e_wr = m_wr;
            end
            if (m_pend && m_age >= (m_legal ? 2 : 1)) e_rv = m_owner ? 2'b10 : 2'b01;

            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("resp_valid", 32'(resp_valid), 32'(e_rv));
            chk("mem_read", 32'(mem_read), 32'(e_rd));
            chk("mem_write", 32'(mem_write), 32'(e_wr));
            if (e_rd || e_wr) begin
                chk("mem_address", mem_address, m_addr);
                chk("mem_funct3", 32'(mem_funct3), 32'(m_f3));
                if (e_wr) chk("mem_write_data", mem_write_data, m_wdata);
            end
            if (e_rv != 2'b00) begin
                chk("resp_rdata", resp_rdata, m_rdata);
                chk("resp_err", 32'(resp_err), 32'(m_err));
            end
            if (mem_write) wr_pulses++;
            if (mem_read || mem_write) mem_act++;

            if (m_pend) begin
                if (m_legal && m_age == 1) begin
                    if (m_wr) begin
                        ref_store(m_addr, m_f3, m_wdata);
                        m_rdata = 32'h0;
                    end else begin
                        m_rdata = ref_load(m_addr, m_f3);
                    end
                    m_err = 1'b0;
                end
                if (e_rv != 2'b00 && resp_ready[m_owner]) m_pend = 1'b0;
                else m_age++;
            end else if (e_ready != 2'b00) begin
                m_pend  = 1'b1;
                m_age   = 1;
                m_owner = m_w;
                m_last  = m_w;
                m_wr    = req_write[m_w];
                m_addr  = req_addr[m_w];
                m_wdata = req_wdata[m_w];
                m_f3    = req_funct3[m_w];
                m_legal = legal(m_wr, m_addr, m_f3);
                if (!m_legal) begin
                    m_rdata = 32'h0;
                    m_err   = 1'b1;
                end
                grant_log.push_back(int'(m_w));
            end
        end
    end

    // Called just after a posedge; returns just after the response handshake edge.
    task automatic issue(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f, output logic [31:0] rd, output bit er, output int lat);
        int n;
        req_valid[p] = 1'b1; req_write[p] = w; req_addr[p] = a; req_wdata[p] = d; req_funct3[p] = f;
        n = 0;
        @(negedge clk);
        while (!req_ready[p] && n < 50) begin @(negedge clk); n++; end
        chk("accept_timeout", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!resp_valid[p] && lat < 50) begin @(negedge clk); lat++; end
        chk("resp_timeout", 32'(lat < 50), 32'd1);
        rd = resp_rdata;
        er = resp_err;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(posedge clk);
        while (m_pend && n < 50) begin @(posedge clk); n++; end
        chk("idle_timeout", 32'(n < 50), 32'd1);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        bit er;
        int lat, base, n;
        for (int i = 0; i < int'(MEM_DEPTH); i++) dmem[i] = 32'h0;
        for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'h0;
        rst = 1'b0; req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
        req_funct3 = '0; resp_ready = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_rw", 32'({mem_read, mem_write}), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Both ports every cycle: strict alternation starting with requester 0.
        base = grant_log.size();
        req_write = 2'b01;
        req_addr[0] = 32'h40; req_wdata[0] = 32'h1122_3344; req_funct3[0] = 3'b010;
        req_addr[1] = 32'h40; req_wdata[1] = 32'h0;         req_funct3[1] = 3'b010;
        req_valid = 2'b11;
        repeat (18) @(posedge clk);
        #1 req_valid = 2'b00;
        wait_idle();
        chk("burst_count", 32'(grant_log.size() - base), 32'd6);
        for (int i = 0; i < 6 && base + i < grant_log.size(); i++)
            chk($sformatf("burst_grant%0d", i), 32'(grant_log[base + i]), 32'(i % 2));

        // Store then load the same word.
        n = wr_pulses;
        issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, rd, er, lat);
        chk("sw_err", 32'(er), 32'd0);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_write_pulses", 32'(wr_pulses - n), 32'd1);
        issue(0, 1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
        chk("lw_rdata", rd, 32'hDEAD_BEEF);
        chk("lw_err", 32'(er), 32'd0);
        chk("lw_latency", 32'(lat), 32'd2);

        // Illegal requests never reach memory.
        n = mem_act;
        issue(1, 1'b0, 32'h13, 32'h0, 3'b001, rd, er, lat);
        chk("lh_mis_err", 32'(er), 32'd1);
        chk("lh_mis_rdata", rd, 32'd0);
        chk("lh_mis_latency", 32'(lat), 32'd1);
        issue(1, 1'b1, 32'h1002, 32'h55, 3'b010, rd, er, lat);
        chk("sw_oob_err", 32'(er), 32'd1);
        issue(1, 1'b1, 32'h10, 32'h0, 3'b100, rd, er, lat);
        chk("s_f3_bad_err", 32'(er), 32'd1);
        issue(0, 1'b0, 32'h1000, 32'h0, 3'b000, rd, er, lat);
        chk("lb_oob_err", 32'(er), 32'd1);
        chk("illegal_no_mem", 32'(mem_act - n), 32'd0);

        // Stalled signed byte load; requester 1 waits behind it.
        issue(0, 1'b1, 32'h10, 32'h0000_8000, 3'b010, rd, er, lat);
        resp_ready = 2'b10;
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h11; req_funct3[0] = 3'b000;
        @(negedge clk);
        chk("lb_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h10; req_funct3[1] = 3'b010;
        n = 0;
        @(negedge clk);
        while (!resp_valid[0] && n < 20) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(resp_valid), 32'd1);
            chk("stall_rdata", resp_rdata, 32'hFFFF_FF80);
            chk("stall_no_grant", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1 resp_ready = 2'b11;
        @(posedge clk);
        @(negedge clk);
        chk("req1_grant_after", 32'(req_ready), 32'd2);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!resp_valid[1] && n < 20) begin @(negedge clk); n++; end
        chk("req1_rdata", resp_rdata, 32'h0000_8000);
        wait_idle();

        // Reset during the ACCESS cycle of a store.
        issue(0, 1'b1, 32'h20, 32'h1234_5678, 3'b010, rd, er, lat);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20;
        req_wdata[0] = 32'hCAFE_F00D; req_funct3[0] = 3'b010;
        @(negedge clk);
        @(posedge clk); #1;
        chk("pre_rst_mem_write", 32'(mem_write), 32'd1);
        req_valid = 2'b00;
        rst = 1'b0;
        #1;
        chk("async_mem_write", 32'(mem_write), 32'd0);
        chk("async_mem_read", 32'(mem_read), 32'd0);
        @(negedge clk);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_rdata", resp_rdata, 32'd0);
        chk("mid_rst_err", 32'(resp_err), 32'd0);
        chk("mid_rst_addr", mem_address, 32'd0);
        chk("mid_rst_wdata", mem_write_data, 32'd0);
        chk("mid_rst_f3", 32'(mem_funct3), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        issue(0, 1'b0, 32'h20, 32'h0, 3'b010, rd, er, lat);
        chk("post_rst_lw", rd, 32'h1234_5678);

        // Top of memory.
        issue(0, 1'b1, MEM_BYTES - 2, 32'h0000_BEEF, 3'b001, rd, er, lat);
        chk("sh_top_err", 32'(er), 32'd0);
        issue(0, 1'b0, MEM_BYTES - 2, 32'h0, 3'b101, rd, er, lat);
        chk("lhu_top_rdata", rd, 32'h0000_BEEF);
        chk("lhu_top_err", 32'(er), 32'd0);
        issue(1, 1'b0, MEM_BYTES - 4, 32'h0, 3'b010, rd, er, lat);
        chk("lw_top_rdata", rd, 32'hBEEF_0000);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
